btb_update_ctrl: RTL

Execute-stage branch resolution and BTB writer. Compares each resolved branch against the prediction carried down the pipeline from the fetch-stage BTB lookup. On a mismatch it issues a one-cycle redirect/flush to fetch. It queues BTB insert/invalidate updates in a 2-entry FIFO and drains them over a valid/ready write port into the BTB.

---
 rtl/btb_update_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: execute-stage branch resolution, fetch redirect and queued BTB updates
//   clk, reset (sync, active-low)
//   exValid/exBranch/exTaken/exPredicted/exPC/exPredTarget/exTarget : resolved instruction and its fetch prediction
//   mispredict/redirectPC : one-cycle flush pulse with the corrected next PC
//   wrValid/wrReady/wrOp/wrTag/wrTarget : BTB insert(1)/invalidate(0) write port, fed by a 2-entry FIFO
//   branchCount/mispredCount (wrapping), dropCount (saturating) : statistics
module btb_update_ctrl #(
  parameter int W_PC  = 8,
  parameter int W_BTA = 32,
  parameter int W_CNT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exValid,
  input  logic             exBranch,
  input  logic             exTaken,
  input  logic             exPredicted,
  input  logic [31:0]      exPC,
  input  logic [W_BTA-1:0] exPredTarget,
  input  logic [W_BTA-1:0] exTarget,
  output logic             mispredict,
  output logic [31:0]      redirectPC,
  output logic             wrValid,
  input  logic             wrReady,
  output logic             wrOp,
  output logic [W_PC-1:0]  wrTag,
  output logic [W_BTA-1:0] wrTarget,
  output logic [W_CNT-1:0] branchCount,
  output logic [W_CNT-1:0] mispredCount,
  output logic [7:0]       dropCount
);
  localparam int W_E = 1 + W_PC + W_BTA;
  typedef enum logic {IDLE, SHADOW} state_t;
  state_t           r_state, w_next;
  logic             w_eval, w_taken_miss, w_nt_miss, w_mis, w_push, w_pop;
  logic [31:0]      w_redir;
  logic [W_E-1:0]   w_entry;
  logic [W_E-1:0]   r_mem [2];
  logic             r_head;
  logic [1:0]       r_cnt;

  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb w_next = (r_state == IDLE && w_mis) ? SHADOW : IDLE;

  // SHADOW holds the wrong-path instruction behind a flush; it must not be evaluated
  always_comb w_eval = exValid && r_state == IDLE;

  always_comb begin
    w_taken_miss = exBranch & exTaken & (!exPredicted | exPredTarget != exTarget);
    // covers both the not-taken hit and a non-branch hitting an aliased tag
    w_nt_miss    = exPredicted & !(exBranch & exTaken);
    w_mis        = w_eval & (w_taken_miss | w_nt_miss);
    w_redir      = w_taken_miss ? 32'(exTarget) : exPC + 32'd4;
    w_entry      = w_taken_miss ? {1'b1, exPC[W_PC-1:0], exTarget} : {1'b0, exPC[W_PC-1:0], {W_BTA{1'b0}}};
    w_pop        = wrValid & wrReady;
    w_push       = w_mis & (!r_cnt[1] | w_pop);
  end

  assign wrValid = r_cnt != 2'd0;
  assign {wrOp, wrTag, wrTarget} = wrValid ? r_mem[r_head] : '0;

  // tail = head + count (mod 2); at count 2 with a pop this reuses the slot being freed
  always_ff @(posedge clk)
    if (w_push) r_mem[r_head ^ r_cnt[0]] <= w_entry;

  always_ff @(posedge clk)
    if (!reset) begin
      r_head <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end

  always_ff @(posedge clk)
    if (!reset) begin
      mispredict   <= 1'b0;
      redirectPC   <= '0;
      branchCount  <= '0;
      mispredCount <= '0;
      dropCount    <= '0;
    end else begin
      mispredict   <= w_mis;
      if (w_mis) redirectPC <= w_redir;
      branchCount  <= branchCount + W_CNT'(w_eval & exBranch);
      mispredCount <= mispredCount + W_CNT'(w_mis);
      if (w_mis && !w_push && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
    end
endmodule
